// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the binary32 divider
// Holds the controller state enum, the special-case class enum, the exponent
// bias/limit, the canonical quiet NaN and the quotient iteration count.
package fp_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_PACK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } special_t;

    localparam int          FP_BIAS      = 127;
    localparam int          FP_EXP_MAX   = 255;
    localparam logic [31:0] FP_QNAN      = 32'h7FC00000;
    localparam int          FP_DIV_STEPS = 26;

endpackage

// File: rtl/fp_divider_if.sv
// rtl/fp_divider_if.sv - start/busy/done request bus of the binary32 divider
// Signals: start, x1, x2 (requester to divider); busy, done, x3, Exception,
// Overflow, Underflow (divider to requester).
// Modports: master = requester side, slave = divider side.
interface fp_divider_if;

    logic        start;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        busy;
    logic        done;
    logic [31:0] x3;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;

    modport master (
        output start, x1, x2,
        input  busy, done, x3, Exception, Overflow, Underflow
    );

    modport slave (
        input  start, x1, x2,
        output busy, done, x3, Exception, Overflow, Underflow
    );

endinterface

// File: rtl/fp_div_core.sv
// rtl/fp_div_core.sv - iterative restoring 24-bit mantissa divider
// Ports: clk, rst (async, active-high); load latches dividend (25 b, already
// normalised into [divisor, 2*divisor)) and divisor (24 b) and clears the step
// counter; each step produces one quotient bit. Outputs: quotient (24 b),
// guard, round, sticky (remainder nonzero), last (the final step is in progress).
module fp_div_core
    import fp_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [24:0] dividend,
    input  logic [23:0] divisor,
    output logic [23:0] quotient,
    output logic        guard,
    output logic        round,
    output logic        sticky,
    output logic        last
);

    logic [24:0] rem;
    logic [23:0] dsr;
    logic [25:0] q;
    logic [4:0]  cnt;
    logic        ge;
    logic [23:0] diff;

    // After a successful subtract the partial remainder is below the divisor,
    // so a 24-bit difference is exact.
    always_comb begin
        ge   = rem >= {1'b0, dsr};
        diff = rem[23:0] - dsr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            dsr <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= dividend;
            dsr <= divisor;
            q   <= '0;
            cnt <= '0;
        end else if (step) begin
            rem <= {(ge ? diff : rem[23:0]), 1'b0};
            q   <= {q[24:0], ge};
            cnt <= cnt + 5'd1;
        end
    end

    assign quotient = q[25:2];
    assign guard    = q[1];
    assign round    = q[0];
    assign sticky   = |rem;
    assign last     = (cnt == 5'(FP_DIV_STEPS - 1));

endmodule

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - sequential IEEE-754 binary32 divider, x3 = x1 / x2
// Ports: clk, rst (async, active-high), bus (fp_divider_if.slave).
// Latency is fixed: start sampled at edge N gives done in the cycle after
// edge N+29. Build option FPDIV_ROUND_EN selects round-to-nearest-even;
// without it the quotient is truncated.
module fp_divider
    import fp_div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fp_divider_if.slave  bus
);

`ifdef FPDIV_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

    state_t state, state_next;
    logic   accept, load, step, pack, commit;

    logic [31:0]        a, b;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    special_t           spc_r;
    logic [31:0]        pend_x3;
    logic               pend_exc, pend_ovf, pend_unf;

    logic [23:0] quotient;
    logic        guard, round, sticky, last;

    // Controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        pack       = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE:   if (bus.start) begin
                           accept     = 1'b1;
                           state_next = ST_UNPACK;
                       end
            ST_UNPACK: begin
                           load       = 1'b1;
                           state_next = ST_DIVIDE;
                       end
            ST_DIVIDE: begin
                           step = 1'b1;
                           if (last) state_next = ST_PACK;
                       end
            ST_PACK:   begin
                           pack       = 1'b1;
                           state_next = ST_DONE;
                       end
            ST_DONE:   begin
                           commit     = 1'b1;
                           state_next = ST_IDLE;
                       end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Unpack: classify operands, form mantissas and biased exponent
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb, ia, ib, na, nb, lt;
    logic [23:0] ma, mb;
    logic [24:0] dividend;
    logic [9:0]  exp_un;
    special_t    spc_un;

    always_comb begin
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        za = (ea == 8'h00);
        zb = (eb == 8'h00);
        ia = (ea == 8'hFF) && (fa == 23'h0);
        ib = (eb == 8'hFF) && (fb == 23'h0);
        na = (ea == 8'hFF) && (fa != 23'h0);
        nb = (eb == 8'hFF) && (fb != 23'h0);
        ma = {1'b1, fa};
        mb = {1'b1, fb};
        // Pre-shifting a smaller dividend guarantees the first quotient bit is 1.
        lt       = ma < mb;
        dividend = lt ? {ma, 1'b0} : {1'b0, ma};
        exp_un   = {2'b00, ea} - {2'b00, eb} + 10'(FP_BIAS) - {9'b0, lt};
        spc_un   = SPC_NONE;
        if (na || nb || (za && zb) || (ia && ib)) spc_un = SPC_NAN;
        else if (ia || zb)                        spc_un = SPC_INF;
        else if (za || ib)                        spc_un = SPC_ZERO;
    end

    // Pack: round, renormalise on carry-out, apply range limits
    logic               inc;
    logic [24:0]        sum;
    logic [22:0]        frac;
    logic signed [9:0]  exp_adj;
    logic [31:0]        pk_x3;
    logic               pk_exc, pk_ovf, pk_unf;

    always_comb begin
        inc     = ROUND_EN & guard & (round | sticky | quotient[0]);
        sum     = {1'b0, quotient} + {24'b0, inc};
        frac    = sum[24] ? sum[23:1] : sum[22:0];
        exp_adj = exp_r + $signed({9'b0, sum[24]});
        pk_x3   = {sign_r, exp_adj[7:0], frac};
        pk_exc  = 1'b0;
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        case (spc_r)
            SPC_NAN:  begin pk_x3 = FP_QNAN;                  pk_exc = 1'b1; end
            SPC_INF:  begin pk_x3 = {sign_r, 8'hFF, 23'h0};   pk_exc = 1'b1; end
            SPC_ZERO: pk_x3 = {sign_r, 31'h0};
            default: begin
                if (exp_adj >= EXP_MAX_S) begin
                    pk_x3  = {sign_r, 8'hFF, 23'h0};
                    pk_ovf = 1'b1;
                end else if (exp_adj <= 10'sd0) begin
                    pk_x3  = {sign_r, 31'h0};
                    pk_unf = 1'b1;
                end
            end
        endcase
    end

    fp_div_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .dividend (dividend),
        .divisor  (mb),
        .quotient (quotient),
        .guard    (guard),
        .round    (round),
        .sticky   (sticky),
        .last     (last)
    );

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            spc_r    <= SPC_NONE;
            pend_x3  <= '0;
            pend_exc <= 1'b0;
            pend_ovf <= 1'b0;
            pend_unf <= 1'b0;
        end else begin
            if (accept) begin
                a <= bus.x1;
                b <= bus.x2;
            end
            if (load) begin
                sign_r <= a[31] ^ b[31];
                exp_r  <= $signed(exp_un);
                spc_r  <= spc_un;
            end
            if (pack) begin
                pend_x3  <= pk_x3;
                pend_exc <= pk_exc;
                pend_ovf <= pk_ovf;
                pend_unf <= pk_unf;
            end
        end
    end

    // Result registers change only on the edge that raises done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.done      <= 1'b0;
            bus.x3        <= '0;
            bus.Exception <= 1'b0;
            bus.Overflow  <= 1'b0;
            bus.Underflow <= 1'b0;
        end else begin
            bus.done <= commit;
            if (commit) begin
                bus.x3        <= pend_x3;
                bus.Exception <= pend_exc;
                bus.Overflow  <= pend_ovf;
                bus.Underflow <= pend_unf;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_divider.sv
// tb/tb_fp_divider.sv - scoreboard bench for fp_divider
module tb_fp_divider;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_divider_if bus ();

    fp_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [34:0] res;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: exact integer quotient of the mantissas, then IEEE-style rounding.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e;
        logic            s;
        logic [22:0]     fa, fb;
        bit              za, zb, ia, ib, na, nb, g, r, st;
        longint unsigned ma, mb, num, qt, mant;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb || (za && zb) || (ia && ib)) return {32'h7FC00000, 3'b100};
        if (ia || zb) return {s, 8'hFF, 23'h0, 3'b100};
        if (za || ib) return {s, 31'h0, 3'b000};
        ma = 64'h800000 + 64'(fa);
        mb = 64'h800000 + 64'(fb);
        e  = ea - eb + 127;
        if (ma >= mb) num = ma << 25;
        else begin
            num = ma << 26;
            e   = e - 1;
        end
        qt   = num / mb;
        st   = (num % mb) != 0;
        g    = qt[1];
        r    = qt[0];
        mant = qt >> 2;
`ifdef FPDIV_ROUND_EN
        if (g && (r || st || mant[0])) mant = mant + 1;
`else
        if (g && r && st) mant = mant + 0;
`endif
        if (mant >= (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
        if (e <= 0)   return {s, 31'h0, 3'b001};
        return {s, 8'(e), mant[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
            3: v[30:23] = 8'($urandom_range(1, 20));
            4: v[30:23] = 8'($urandom_range(235, 254));
            5: v[22:0] = 23'h0;
            default: ;
        endcase
        return v;
    endfunction

    // Monitor: every done must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {bus.x3, bus.Exception, bus.Overflow, bus.Underflow}, 64'h0);
                end else begin
                    e = sbq.pop_front();
                    check("result", {bus.x3, bus.Exception, bus.Overflow, bus.Underflow}, e.res);
                    check("latency", cyc, e.due);
                    check("busy_at_done", bus.busy, 0);
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
                check("done_at_due", bus.done, 1);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] want);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x1    = a;
        bus.x2    = b;
        e.res     = want;
        e.due     = cyc + 30;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (28) @(negedge clk);
    endtask

    logic [31:0] third;
    int          c0;
    exp_t        ex;
    logic [31:0] ra, rb;

    initial begin
`ifdef FPDIV_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x1    = '0;
        bus.x2    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_outputs", {bus.x3, bus.Exception, bus.Overflow, bus.Underflow}, 0);
        rst = 1'b0;

        issue(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000});
        issue(32'h40F00000, 32'hC0200000, {32'hC0400000, 3'b000});
        issue(32'h3F800000, 32'h40400000, {third,        3'b000});
        issue(32'h3F800000, 32'h00000000, {32'h7F800000, 3'b100});
        issue(32'h7F800000, 32'h7F800000, {32'h7FC00000, 3'b100});
        issue(32'hFF800000, 32'h40000000, {32'hFF800000, 3'b100});
        issue(32'h7F000000, 32'h00800000, {32'h7F800000, 3'b010});
        issue(32'h00800000, 32'h40000000, {32'h00000000, 3'b001});
        issue(32'h80000000, 32'h40000000, {32'h80000000, 3'b000});
        issue(32'h40000000, 32'hFF800000, {32'h80000000, 3'b000});
        issue(32'h7FC00001, 32'h3F800000, {32'h7FC00000, 3'b100});

        // start pulses mid-operation must be ignored
        @(negedge clk);
        c0 = cyc;
        bus.start = 1'b1;
        bus.x1    = 32'h40400000;
        bus.x2    = 32'h3F800000;
        ex.res    = {32'h40400000, 3'b000};
        ex.due    = c0 + 30;
        sbq.push_back(ex);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.x1    = 32'h3F800000;
        bus.x2    = 32'h00000000;
        check("busy_cycle5", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.start = 1'b1;
        check("busy_cycle20", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);

        // start held high: two results 30 cycles apart
        @(negedge clk);
        c0 = cyc;
        bus.start = 1'b1;
        bus.x1    = 32'h41200000;
        bus.x2    = 32'h40A00000;
        ex.res    = {32'h40000000, 3'b000};
        ex.due    = c0 + 30;
        sbq.push_back(ex);
        ex.due    = c0 + 60;
        sbq.push_back(ex);
        repeat (60) @(negedge clk);
        bus.start = 1'b0;

        // reset mid-operation aborts with no done
        @(negedge clk);
        c0 = cyc;
        bus.start = 1'b1;
        bus.x1    = 32'h40C00000;
        bus.x2    = 32'h40000000;
        ex.res    = {32'h40400000, 3'b000};
        ex.due    = c0 + 30;
        sbq.push_back(ex);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_outputs", {bus.done, bus.x3, bus.Exception, bus.Overflow, bus.Underflow}, 0);
        void'(sbq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(32'h40F00000, 32'hC0200000, {32'hC0400000, 3'b000});

        for (int i = 0; i < 50; i++) begin
            ra = rand_op();
            rb = rand_op();
            issue(ra, rb, model(ra, rb));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

endmodule
